result_display: RTL and testbench

Output-side counterpart to the keypad input unit: accepts a 32-bit two's-complement result from the arithmetic unit, converts it to sign-magnitude and then to packed BCD with a sequential double-dabble engine, formats it for a 6-digit display, and drives a multiplexed active-low 7-segment display. Its BCD nibble encoding matches the input unit's display bus: 0xF means blank, 0xA means minus sign, and 0xE means error. Input-unit display data and result data can therefore share one display path upstream.

---
 rtl/result_display.sv | 226 ++++++++++++++++++++++
 tb/tb_result_display.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
`default_nettype none
// ============================================================================
// Module  : result_display
// Brief   : Two's-complement result -> sign-magnitude -> packed BCD via a
//           sequential double-dabble engine, formatted for a 6-digit display
//           and scanned onto a multiplexed active-low 7-segment display.
//           Nibble codes: 0xF blank, 0xA minus sign, 0xE error.
// Revision: 1.0 - initial release
// ============================================================================
module result_display #(
  parameter int N           = 32,
  parameter int DIGITS      = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [N-1:0]          tcBinary,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   BCD_O,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg
);

  // Decimal digits needed to hold any N-bit magnitude: ceil(N*log10(2)).
  localparam int c_acc_digits = (N * 30103) / 100000 + 1;
  localparam int c_acc_w      = 4 * c_acc_digits;
  localparam int c_cnt_w      = $clog2(N);
  localparam int c_ref_w      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_idx_w      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [N-1:0]       c_one      = N'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);
  localparam logic [c_ref_w-1:0] c_ref_one  = c_ref_w'(1);
  localparam logic [c_ref_w-1:0] c_ref_last = c_ref_w'(REFRESH_DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);
  localparam logic [DIGITS-1:0]  c_an_one   = DIGITS'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FORMAT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_start;
  logic                  w_shift;
  logic                  w_format;

  logic                  r_sign;
  logic [N-1:0]          r_mag;
  logic [c_acc_w-1:0]    r_acc;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [N-1:0]          w_mag_in;
  logic [c_acc_w-1:0]    w_acc_adj;

  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_ovf;
  logic                  r_done;
  logic [4*DIGITS-1:0]   w_bcd_fmt;
  logic                  w_ovf;
  int                    w_msd;

  logic [c_ref_w-1:0]    r_refresh;
  logic [c_idx_w-1:0]    r_index;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_seg;
  logic [c_idx_w-1:0]    w_index_next;
  logic [DIGITS-1:0]     w_an_next;
  logic [3:0]            w_digit_nib;
  logic [6:0]            w_seg_next;

  // Magnitude of the incoming value; -2^(N-1) maps to 2^(N-1) as unsigned.
  assign w_mag_in = tcBinary[N-1] ? (~tcBinary + c_one) : tcBinary;

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  generate
    for (genvar gi = 0; gi < c_acc_digits; gi++) begin : g_adj
      assign w_acc_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ?
                                    (r_acc[4*gi +: 4] + 4'd3) : r_acc[4*gi +: 4];
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state and datapath control strobes.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_format     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_start      = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == c_cnt_last) w_state_next = S_FORMAT;
      end
      S_FORMAT: begin
        w_format     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Conversion datapath: latch sign/magnitude, then shift one bit per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sign <= 1'b0;
      r_mag  <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_sign <= tcBinary[N-1];
      r_mag  <= w_mag_in;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (w_shift) begin
      r_acc  <= {w_acc_adj[c_acc_w-2:0], r_mag[N-1]};
      r_mag  <= {r_mag[N-2:0], 1'b0};
      r_cnt  <= r_cnt + c_cnt_one;
    end
  end

  // Display formatting: overflow detection, leading-zero blanking, minus sign.
  always_comb begin
    w_ovf     = 1'b0;
    w_msd     = 0;
    w_bcd_fmt = '1;
    for (int i = DIGITS; i < c_acc_digits; i++) begin
      if (r_acc[4*i +: 4] != 4'd0) w_ovf = 1'b1;
    end
    // A negative value needs the top display digit free for the minus sign.
    if (r_sign && (r_acc[4*(DIGITS-1) +: 4] != 4'd0)) w_ovf = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_acc[4*i +: 4] != 4'd0) w_msd = i;
    end
    if (w_ovf) begin
      w_bcd_fmt[3:0] = 4'hE;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (i <= w_msd)                    w_bcd_fmt[4*i +: 4] = r_acc[4*i +: 4];
        else if (r_sign && i == w_msd + 1) w_bcd_fmt[4*i +: 4] = 4'hA;
      end
    end
  end

  // Result registers: only updated in FORMAT so the display never sees partial data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd  <= '1;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_format;
      if (w_format) begin
        r_bcd <= w_bcd_fmt;
        r_ovf <= w_ovf;
      end
    end
  end

  assign w_index_next = (r_index == c_idx_last) ? '0 : (r_index + c_idx_one);
  assign w_an_next    = ~(c_an_one << w_index_next);
  assign w_digit_nib  = r_bcd[4*w_index_next +: 4];

  // Seven-segment glyph lookup for the digit about to be lit.
  always_comb begin
    w_seg_next = 7'b1111111;
    case (w_digit_nib)
      4'h0:    w_seg_next = 7'b1000000;
      4'h1:    w_seg_next = 7'b1111001;
      4'h2:    w_seg_next = 7'b0100100;
      4'h3:    w_seg_next = 7'b0110000;
      4'h4:    w_seg_next = 7'b0011001;
      4'h5:    w_seg_next = 7'b0010010;
      4'h6:    w_seg_next = 7'b0000010;
      4'h7:    w_seg_next = 7'b1111000;
      4'h8:    w_seg_next = 7'b0000000;
      4'h9:    w_seg_next = 7'b0010000;
      4'hA:    w_seg_next = 7'b0111111;
      4'hE:    w_seg_next = 7'b0000110;
      default: w_seg_next = 7'b1111111;
    endcase
  end

  // Display scan: advance digit and re-register an/seg on refresh wrap only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh <= '0;
      r_index   <= '0;
      r_an      <= ~c_an_one;
      r_seg     <= 7'b1111111;
    end else if (r_refresh == c_ref_last) begin
      r_refresh <= '0;
      r_index   <= w_index_next;
      r_an      <= w_an_next;
      r_seg     <= w_seg_next;
    end else begin
      r_refresh <= r_refresh + c_ref_one;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign overflow = r_ovf;
  assign BCD_O    = r_bcd;
  assign an       = r_an;
  assign seg      = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_result_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_result_display
// Brief   : Self-checking bench for result_display with an arithmetic
//           reference model of the display formatting rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_result_display;
  localparam int N           = 32;
  localparam int DIGITS      = 6;
  localparam int REFRESH_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] tcBinary;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [23:0] BCD_O;
  logic [5:0]  an;
  logic [6:0]  seg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  result_display #(.N(N), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk(clk), .reset(reset), .load(load), .tcBinary(tcBinary),
    .busy(busy), .done(done), .overflow(overflow), .BCD_O(BCD_O),
    .an(an), .seg(seg)
  );

  // Reference: decimal formatting by plain integer arithmetic.
  function automatic void model(input logic [31:0] v, output logic [23:0] b, output logic o);
    longint s;
    longint m;
    bit     neg;
    int     i;
    s   = longint'($signed(v));
    neg = (s < 0);
    m   = neg ? -s : s;
    b   = 24'hFFFFFF;
    o   = 1'b0;
    if (m >= 1000000 || (neg && m >= 100000)) begin
      b = 24'hFFFFFE;
      o = 1'b1;
    end else begin
      i = 0;
      do begin
        b[4*i +: 4] = 4'(m % 10);
        m = m / 10;
        i++;
      end while (m != 0);
      if (neg) b[4*i +: 4] = 4'hA;
    end
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0111111;  4'hE: return 7'b0000110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; tcBinary = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (BCD_O !== 24'hFFFFFF) begin errors++; $display("FAIL reset_bcd: got %h want ffffff", BCD_O); end
    checks++; if (an !== 6'b111110)     begin errors++; $display("FAIL reset_an: got %b want 111110", an); end
    checks++; if (seg !== 7'b1111111)   begin errors++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    @(negedge clk); reset = 1'b0;
  endtask

  // One conversion with latency, hold, result and done-pulse checks.
  task automatic run_conv(input logic [31:0] v);
    logic [23:0] eb;
    logic        eo;
    logic [23:0] prev;
    int          lat;
    bit          held_bad;
    model(v, eb, eo);
    prev = BCD_O;
    held_bad = 1'b0;
    @(negedge clk); load = 1'b1; tcBinary = v;
    @(posedge clk); #1; load = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL conv_busy_start v=%h: got %b want 1", v, busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (BCD_O !== prev) held_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat != 33)      begin errors++; $display("FAIL conv_latency v=%h: got %0d want 33", v, lat); end
    checks++; if (held_bad)       begin errors++; $display("FAIL conv_hold v=%h: got changed want held %h", v, prev); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL conv_busy_end v=%h: got %b want 0", v, busy); end
    checks++; if (BCD_O !== eb)   begin errors++; $display("FAIL conv_bcd v=%h: got %h want %h", v, BCD_O, eb); end
    checks++; if (overflow !== eo) begin errors++; $display("FAIL conv_ovf v=%h: got %b want %b", v, overflow, eo); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL conv_done_drop v=%h: got %b want 0", v, done); end
  endtask

  task automatic test_directed();
    run_conv(32'd1234);
    run_conv(-32'sd45);
    run_conv(32'd0);
    run_conv(32'd999999);
    run_conv(-32'sd99999);
    run_conv(-32'sd100000);
    run_conv(32'd1000000);
    run_conv(32'h80000000);
    run_conv(32'd7);
  endtask

  task automatic test_random();
    int base [8] = '{99999, 100000, -99999, -100000, 999999, 1000000, -1, 1};
    int v;
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom);
        1:       v = int'($urandom_range(0, 999999));
        2:       v = -int'($urandom_range(1, 99999));
        default: v = base[$urandom_range(0, 7)] + int'($urandom_range(0, 2)) - 1;
      endcase
      run_conv(v);
    end
  endtask

  task automatic test_load_ignored();
    logic [23:0] eb;
    logic        eo;
    logic [23:0] captured;
    int          dones;
    model(32'd777, eb, eo);
    captured = '0;
    @(negedge clk); load = 1'b1; tcBinary = 32'd777;
    @(posedge clk); #1; load = 1'b0;
    dones = 0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 10) begin load = 1'b1; tcBinary = 32'd555; end
      if (c == 11) load = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin dones++; if (dones == 1) captured = BCD_O; end
    end
    checks++; if (dones != 1)      begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    checks++; if (captured !== eb) begin errors++; $display("FAIL ignore_bcd: got %h want %h", captured, eb); end
    // Second conversion aborted by reset at cycle 20.
    @(negedge clk); load = 1'b1; tcBinary = 32'd4321;
    @(posedge clk); #1; load = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (BCD_O !== 24'hFFFFFF) begin errors++; $display("FAIL abort_bcd: got %h want ffffff", BCD_O); end
    checks++; if (an !== 6'b111110)     begin errors++; $display("FAIL abort_an: got %b want 111110", an); end
    @(negedge clk); reset = 1'b0;
    dones = 0;
    repeat (50) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
    checks++; if (dones != 0)           begin errors++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    checks++; if (BCD_O !== 24'hFFFFFF) begin errors++; $display("FAIL abort_bcd_after: got %h want ffffff", BCD_O); end
  endtask

  // load held high: second value accepted on the first IDLE edge after FORMAT.
  task automatic test_back_to_back();
    logic [23:0] e1, e2;
    logic        o1, o2;
    int          lat;
    model(32'd86420, e1, o1);
    model(-32'sd3071, e2, o2);
    @(negedge clk); load = 1'b1; tcBinary = 32'd86420;
    @(posedge clk); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 33)    begin errors++; $display("FAIL b2b_lat1: got %0d want 33", lat); end
    checks++; if (BCD_O !== e1) begin errors++; $display("FAIL b2b_bcd1: got %h want %h", BCD_O, e1); end
    tcBinary = -32'sd3071;
    @(posedge clk); #1; load = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 33)    begin errors++; $display("FAIL b2b_lat2: got %0d want 33", lat); end
    checks++; if (BCD_O !== e2) begin errors++; $display("FAIL b2b_bcd2: got %h want %h", BCD_O, e2); end
  endtask

  task automatic test_scan();
    logic [23:0] eb;
    logic        eo;
    logic [5:0]  prev_an;
    logic [5:0]  exp_an;
    logic [6:0]  exp_seg;
    bit          found;
    int          idx;
    run_conv(-32'sd45);
    model(-32'sd45, eb, eo);
    prev_an = an;
    found   = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (an === 6'b111110 && prev_an !== 6'b111110) found = 1'b1;
      prev_an = an;
    end
    checks++; if (!found) begin errors++; $display("FAIL scan_sync: got no wrap to digit 0 want wrap"); end
    if (found) begin
      for (int p = 0; p < 2 * DIGITS; p++) begin
        idx     = p % DIGITS;
        exp_an  = ~(6'b000001 << idx);
        exp_seg = glyph(eb[4*idx +: 4]);
        for (int c = 0; c < REFRESH_DIV; c++) begin
          checks++;
          if (an !== exp_an || seg !== exp_seg) begin
            errors++;
            $display("FAIL scan p=%0d c=%0d: got an=%b seg=%b want an=%b seg=%b", p, c, an, seg, exp_an, exp_seg);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_load_ignored();
    test_back_to_back();
    test_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
